hmm_frame_sched: RTL

- Frame scheduler that sequences the Gaussian HMM log-likelihood engine (gbHMM) once per feature frame.
- Accepts feature frames of DIM words over a valid/ready stream into a ping-pong frame buffer.
- For each frame it drives the engine's start/x_i load protocol, then collects the STATE per-state scores (x_o, out_index, dv).
- Emits the best-scoring state and its score per frame to the downstream Viterbi stage.

---
 rtl/hmm_pkg.sv | 11 +
 rtl/hmm_pingpong_buf.sv | 58 +++++
 rtl/hmm_frame_sched.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/hmm_pkg.sv
// Shared constants and FSM encoding for the HMM frame scheduler.
package hmm_pkg;
  localparam int unsigned DIM         = 12;
  localparam int unsigned STATE       = 12;
  localparam int unsigned BWIDTH      = 16;
  localparam int unsigned SCORE_W     = 64;
  localparam int unsigned WDOG_CYCLES = 1024;
  localparam logic signed [SCORE_W-1:0] SCORE_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FEED, RUN, POST} state_t;
endpackage

// File: rtl/hmm_pingpong_buf.sv
// Two-bank feature frame buffer: stream write side, indexed read side with release.
module hmm_pingpong_buf #(
  parameter int unsigned DIM = 12,
  parameter int unsigned W   = 32,
  parameter int unsigned IW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [W-1:0]  i_data,
  output logic          o_rd_full,
  input  logic [IW-1:0] i_rd_idx,
  output logic [W-1:0]  o_rd_data,
  input  logic          i_release
);
  import hmm_pkg::*;

  logic [W-1:0]  r_mem [0:1][0:DIM-1];
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [IW-1:0] r_wr_cnt;
  logic          w_wr;
  logic          w_wr_last;

  always_comb begin
    o_ready   = !r_full[r_wr_bank];
    o_rd_full = r_full[r_rd_bank];
    o_rd_data = r_mem[r_rd_bank][i_rd_idx];
    w_wr      = i_valid && o_ready;
    w_wr_last = w_wr && (r_wr_cnt == IW'(DIM-1));
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_bank][r_wr_cnt] <= i_data;
  end

  // Fill and release always target different banks, so both updates can land together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_wr) r_wr_cnt <= w_wr_last ? '0 : r_wr_cnt + IW'(1);
      if (w_wr_last) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (i_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_rd_bank         <= ~r_rd_bank;
      end
    end
  end
endmodule

// File: rtl/hmm_frame_sched.sv
// Sequences the gbHMM engine once per buffered feature frame and reports the
// argmax state/score per frame downstream.
module hmm_frame_sched #(
  parameter int unsigned DIM     = hmm_pkg::DIM,
  parameter int unsigned STATE   = hmm_pkg::STATE,
  parameter int unsigned BWIDTH  = hmm_pkg::BWIDTH,
  parameter int unsigned SCORE_W = hmm_pkg::SCORE_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [2*BWIDTH-1:0]       in_data,
  output logic                      eng_start,
  output logic [2*BWIDTH-1:0]       eng_x_i,
  input  logic                      eng_load,
  input  logic                      eng_dv,
  input  logic [15:0]               eng_out_index,
  input  logic signed [SCORE_W-1:0] eng_x_o,
  input  logic                      eng_done,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [15:0]               res_state,
  output logic signed [SCORE_W-1:0] res_score,
  output logic [15:0]               res_frame,
  output logic                      err
);
  import hmm_pkg::*;

  localparam int unsigned IW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned WW = $clog2(WDOG_CYCLES);
  localparam logic signed [SCORE_W-1:0] S_MIN = {1'b1, {(SCORE_W-1){1'b0}}};

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [IW-1:0]             r_feed_cnt;
  logic [15:0]               r_exp_idx;
  logic signed [SCORE_W-1:0] r_best_score;
  logic [15:0]               r_best_state;
  logic [WW-1:0]             r_run_cnt;
  logic [15:0]               r_frame_cnt;
  logic                      r_eng_start;
  logic [2*BWIDTH-1:0]       r_eng_x_i;
  logic                      r_res_valid;
  logic [15:0]               r_res_state;
  logic signed [SCORE_W-1:0] r_res_score;
  logic [15:0]               r_res_frame;
  logic                      r_err;

  logic                      w_rd_full;
  logic [2*BWIDTH-1:0]       w_rd_data;
  logic [IW-1:0]             w_rd_idx;
  logic                      w_release;
  logic                      w_res_pend;
  logic                      w_feed_last;
  logic                      w_wdog;
  logic [15:0]               w_exp_nxt;

  hmm_pingpong_buf #(
    .DIM (DIM),
    .W   (2*BWIDTH),
    .IW  (IW)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (in_valid),
    .o_ready   (in_ready),
    .i_data    (in_data),
    .o_rd_full (w_rd_full),
    .i_rd_idx  (w_rd_idx),
    .o_rd_data (w_rd_data),
    .i_release (w_release)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_rd_idx    = '0;
    w_release   = 1'b0;
    w_res_pend  = r_res_valid && !res_ready;
    w_feed_last = (r_feed_cnt == IW'(DIM-1));
    w_wdog      = (r_run_cnt == WW'(WDOG_CYCLES-1));
    w_exp_nxt   = r_exp_idx + 16'(eng_dv);
    unique case (r_state)
      IDLE: if (w_rd_full && !w_res_pend) w_state_nxt = FEED;
      // x_i is registered, so the read port runs one word ahead of feed_cnt.
      FEED: begin
        if (w_feed_last) begin
          w_release   = 1'b1;
          w_state_nxt = RUN;
        end else begin
          w_rd_idx = r_feed_cnt + IW'(1);
        end
      end
      RUN:     if (eng_done || w_wdog) w_state_nxt = POST;
      POST:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_feed_cnt   <= '0;
      r_exp_idx    <= '0;
      r_best_score <= S_MIN;
      r_best_state <= '0;
      r_run_cnt    <= '0;
      r_frame_cnt  <= '0;
      r_eng_start  <= 1'b0;
      r_eng_x_i    <= '0;
      r_res_valid  <= 1'b0;
      r_res_state  <= '0;
      r_res_score  <= '0;
      r_res_frame  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_res_valid && res_ready) r_res_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_state_nxt == FEED) begin
            r_eng_start <= 1'b1;
            r_eng_x_i   <= w_rd_data;
            r_feed_cnt  <= '0;
          end
        end
        FEED: begin
          if (w_feed_last) begin
            r_best_score <= S_MIN;
            r_best_state <= '0;
            r_exp_idx    <= '0;
            r_run_cnt    <= '0;
          end else begin
            r_eng_x_i  <= w_rd_data;
            r_feed_cnt <= r_feed_cnt + IW'(1);
          end
        end
        RUN: begin
          if (eng_dv) begin
            if (eng_out_index != r_exp_idx) r_err <= 1'b1;
            if (eng_x_o > r_best_score) begin
              r_best_score <= eng_x_o;
              r_best_state <= eng_out_index;
            end
            r_exp_idx <= w_exp_nxt;
          end
          if (eng_done) begin
            if (w_exp_nxt != 16'(STATE)) r_err <= 1'b1;
          end else if (w_wdog) begin
            r_err <= 1'b1;
          end
          r_run_cnt <= r_run_cnt + WW'(1);
          if (w_state_nxt == POST) r_eng_start <= 1'b0;
        end
        POST: begin
          r_res_valid <= 1'b1;
          r_res_state <= r_best_state;
          r_res_score <= r_best_score;
          r_res_frame <= r_frame_cnt;
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
        default: ;
      endcase
      // The engine still holds done during POST while it observes start low.
      if (r_state != RUN && (eng_dv || (eng_done && r_state != POST))) r_err <= 1'b1;
    end
  end

  always_comb begin
    eng_start = r_eng_start;
    eng_x_i   = r_eng_x_i;
    res_valid = r_res_valid;
    res_state = r_res_state;
    res_score = r_res_score;
    res_frame = r_res_frame;
    err       = r_err;
  end

  a_load_during_feed: assert property (@(posedge clk) disable iff (reset)
    (r_state == FEED && r_feed_cnt != '0) |-> eng_load);
endmodule
